led_beacon_tx: RTL and testbench
================================

LED_BEACON_TX -- requirements
Module: led_beacon_tx

Interface
REQ-001 SHALL provide parameter HALF_RED, default 50000, half-period in clocks of the red carrier (1 kHz).
REQ-002 SHALL provide parameter HALF_BLUE, default 25000, half-period in clocks of the blue carrier (2 kHz).
REQ-003 SHALL provide parameter HALF_GREEN, default 16667, half-period in clocks of the green carrier (~3 kHz).
REQ-004 SHALL provide parameter HALF_YELLOW, default 12500, half-period in clocks of the yellow carrier (4 kHz).
REQ-005 SHALL provide parameter MARK_PERIODS, default 100, number of full carrier periods per burst.
REQ-006 SHALL provide parameter SPACE_CLKS, default 10000000, gap between bursts in clocks (100 ms).
REQ-007 SHALL have port CLK100MHZ, input, 1 bit, system clock, 100 MHz.
REQ-008 SHALL have port reset, input, 1 bit; reset is synchronous and active-low, and CLK100MHZ is the clock.
REQ-009 SHALL have port enable, input, 1 bit, level; 1 = beacon running.
REQ-010 SHALL have port color_sel, input, 3 bits: 000 red, 001 blue, 010 green, 011 yellow, 1xx unknown.
REQ-011 SHALL have port color_load, input, 1 bit, single-cycle strobe that captures color_sel.
REQ-012 SHALL have port led_out, output, 1 bit, carrier drive to the IR/visible LED.
REQ-013 SHALL have port bursting, output, 1 bit, high while in MARK.
REQ-014 SHALL have port burst_done, output, 1 bit, one-cycle pulse at the end of each MARK.
REQ-015 SHALL have port active_color, output, 3 bits, the color code currently transmitting.

Function
REQ-016 SHALL hold a pending color register, written from color_sel on every cycle color_load=1; the last strobe wins.
REQ-017 SHALL copy pending to active_color only on the IDLE->MARK or SPACE->MARK transition, so a burst never changes frequency mid-burst.
REQ-018 SHALL implement the states IDLE, MARK and SPACE.
REQ-019 IDLE: led_out=0; go to MARK on the next cycle when enable=1 and pending is a valid color (0xx).
REQ-020 MARK: toggle led_out each time the half-period counter reaches HALF_x-1, then restart the counter at 0; led_out SHALL start at 1 on MARK entry.
REQ-021 MARK SHALL end after exactly 2*MARK_PERIODS toggles, with led_out=0 afterwards; burst_done SHALL pulse on that cycle, and the next state SHALL be SPACE.
REQ-022 SPACE: led_out=0 for exactly SPACE_CLKS cycles.
REQ-023 At the end of SPACE: go to MARK if enable=1 and pending is valid, otherwise go to IDLE.
REQ-024 Counter widths: half-period 17 bits, toggle count 16 bits, space 24 bits; parameters SHALL be range-checked at elaboration.
REQ-025 enable deasserting in MARK SHALL let the current burst complete; the block then goes through SPACE to IDLE.
REQ-026 An unknown color (1xx) in pending SHALL suppress new bursts but SHALL NOT abort a burst in progress.
REQ-027 color_load and a burst-start transition in the same cycle: the newly loaded color SHALL be used for that burst.
REQ-028 Counters SHALL never wrap; every counter SHALL be cleared on each state entry.
REQ-029 bursting SHALL equal (state==MARK), and SHALL be registered.

Reset
REQ-030 While reset=0 at a clock edge: state=IDLE, led_out=0, bursting=0, burst_done=0, active_color=3'b100, pending=3'b100, and all counters 0.
REQ-031 Reset asserted mid-burst SHALL force led_out=0 on the same edge; there SHALL be no residual pulse.
REQ-032 After reset is released, no burst SHALL start until color_load has delivered a valid color.

Verification
REQ-033 Load 000, enable=1 -> MARK within 2 cycles; led_out period 100000 clocks; 200 toggles; burst_done at the end; 10000000 clocks low; MARK repeats.
REQ-034 Load 011 during a red MARK -> the rest of that burst stays at 50000 half-period; the next burst uses 12500; active_color changes at MARK entry.
REQ-035 Load 100 while in SPACE -> after SPACE the state goes to IDLE, and led_out stays 0 indefinitely.
REQ-036 Drop enable midway through MARK -> the burst completes its full 200 toggles, then SPACE, then IDLE, with bursting=0.
REQ-037 Assert reset at toggle 57 of a burst -> led_out=0 on the next edge and all outputs at reset values; with no reload, no burst after release.
REQ-038 Set HALF_BLUE=3, MARK_PERIODS=2, SPACE_CLKS=5 -> exact cycle trace: 4 toggles 3 clocks apart, burst_done once, 5 low clocks.

Source files
------------

// File: rtl/led_beacon_tx.sv
// led_beacon_tx: burst-modulated LED carrier beacon with selectable per-color frequency
module led_beacon_tx #(
   parameter int HALF_RED     = 50000,
   parameter int HALF_BLUE    = 25000,
   parameter int HALF_GREEN   = 16667,
   parameter int HALF_YELLOW  = 12500,
   parameter int MARK_PERIODS = 100,
   parameter int SPACE_CLKS   = 10000000
) (
   input  logic       CLK100MHZ,
   input  logic       reset,
   input  logic       enable,
   input  logic [2:0] color_sel,
   input  logic       color_load,
   output logic       led_out,
   output logic       bursting,
   output logic       burst_done,
   output logic [2:0] active_color
);
   localparam bit PARAM_OK =
      HALF_RED >= 1 && HALF_RED <= 131072 && HALF_BLUE >= 1 && HALF_BLUE <= 131072 &&
      HALF_GREEN >= 1 && HALF_GREEN <= 131072 && HALF_YELLOW >= 1 && HALF_YELLOW <= 131072 &&
      MARK_PERIODS >= 1 && 2 * MARK_PERIODS <= 65535 && SPACE_CLKS >= 1 && SPACE_CLKS <= 16777216;
   if (!PARAM_OK) begin : g_bad_params
      $error("led_beacon_tx: parameter out of counter range");
   end
   localparam logic [16:0] H_RED    = 17'(HALF_RED - 1);
   localparam logic [16:0] H_BLUE   = 17'(HALF_BLUE - 1);
   localparam logic [16:0] H_GREEN  = 17'(HALF_GREEN - 1);
   localparam logic [16:0] H_YELLOW = 17'(HALF_YELLOW - 1);
   localparam logic [15:0] T_LAST   = 16'(2 * MARK_PERIODS - 1);
   localparam logic [23:0] S_LAST   = 24'(SPACE_CLKS - 1);
   typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;
   state_t      state, state_n;
   logic [2:0]  pending, pending_n, color_n;
   logic [16:0] hc, hc_n, half_lim;
   logic [15:0] tc, tc_n;
   logic [23:0] sc, sc_n;
   logic        led_n, done_n, start;
   // a strobe in the same cycle as a burst start must win, so look through the register
   assign pending_n = color_load ? color_sel : pending;
   assign start     = enable && !pending_n[2];
   // carrier half-period follows the color latched at burst entry, never the pending one
   always_comb
      half_lim = active_color[1:0] == 2'd0 ? H_RED :
                 active_color[1:0] == 2'd1 ? H_BLUE :
                 active_color[1:0] == 2'd2 ? H_GREEN : H_YELLOW;
   // next state and next register values; counters default to zero so every entry clears them
   always_comb begin
      state_n = state;
      hc_n    = '0;
      tc_n    = '0;
      sc_n    = '0;
      led_n   = 1'b0;
      done_n  = 1'b0;
      color_n = active_color;
      if (state == IDLE) begin
         if (start) begin
            state_n = MARK;
            led_n   = 1'b1;
            color_n = pending_n;
         end
      end else if (state == MARK) begin
         hc_n  = hc + 17'd1;
         tc_n  = tc;
         led_n = led_out;
         if (hc == half_lim) begin
            hc_n  = '0;
            tc_n  = tc + 16'd1;
            led_n = !led_out;
            if (tc == T_LAST) begin
               state_n = SPACE;
               tc_n    = '0;
               led_n   = 1'b0;
               done_n  = 1'b1;
            end
         end
      end else begin
         sc_n = sc + 24'd1;
         if (sc == S_LAST) begin
            sc_n    = '0;
            state_n = start ? MARK : IDLE;
            led_n   = start;
            color_n = start ? pending_n : active_color;
         end
      end
   end
   // state and output registers; reset clears the LED on the same edge
   always_ff @(posedge CLK100MHZ) begin
      if (!reset) begin
         state        <= IDLE;
         pending      <= 3'b100;
         active_color <= 3'b100;
         led_out      <= 1'b0;
         bursting     <= 1'b0;
         burst_done   <= 1'b0;
         hc           <= '0;
         tc           <= '0;
         sc           <= '0;
      end else begin
         state        <= state_n;
         pending      <= pending_n;
         active_color <= color_n;
         led_out      <= led_n;
         bursting     <= state_n == MARK;
         burst_done   <= done_n;
         hc           <= hc_n;
         tc           <= tc_n;
         sc           <= sc_n;
      end
   end
endmodule

// File: tb/tb_led_beacon_tx.sv
// tb_led_beacon_tx: directed vector table plus multi-cycle burst sequences for led_beacon_tx
module tb_led_beacon_tx;
   logic       clk = 1'b0;
   logic       reset = 1'b0, enable = 1'b0, color_load = 1'b0;
   logic [2:0] color_sel = 3'd0;
   logic       led_out, bursting, burst_done;
   logic [2:0] active_color;
   int         n_vec = 0, n_bad = 0;
   int         len, hi, dn, n;

   typedef struct {
      logic       rst, en, load;
      logic [2:0] sel;
      logic       led, bur, done;
      logic [2:0] col;
   } vec_t;
   vec_t tv[19];

   led_beacon_tx #(
      .HALF_RED(4), .HALF_BLUE(3), .HALF_GREEN(5), .HALF_YELLOW(2),
      .MARK_PERIODS(2), .SPACE_CLKS(5)
   ) dut (
      .CLK100MHZ(clk), .reset(reset), .enable(enable), .color_sel(color_sel),
      .color_load(color_load), .led_out(led_out), .bursting(bursting),
      .burst_done(burst_done), .active_color(active_color)
   );

   always #5 clk = !clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // run while bursting is high, counting burst cycles and LED-high cycles
   task automatic measure(input int load_at, input logic [2:0] sel, input int drop_at,
                          output int l, output int h, output int d);
      l = 0;
      h = 0;
      while (bursting && l < 200) begin
         l++;
         h += int'(led_out);
         color_sel  = sel;
         color_load = (l == load_at);
         if (l == drop_at) enable = 1'b0;
         step();
         color_load = 1'b0;
      end
      d = int'(burst_done);
   endtask

   // wait up to max cycles for a burst to start, summing LED-high cycles meanwhile
   task automatic wait_mark(input int max, output int w, output int h);
      w = 0;
      h = 0;
      while (!bursting && w < max) begin
         h += int'(led_out);
         step();
         w++;
      end
   endtask

   initial begin
      tv[0]  = '{1'b0, 1'b0, 1'b0, 3'd0,     1'b0, 1'b0, 1'b0, 3'b100};
      tv[1]  = '{1'b1, 1'b1, 1'b1, 3'b001,   1'b1, 1'b1, 1'b0, 3'b001};
      tv[2]  = '{1'b1, 1'b1, 1'b0, 3'd0,     1'b1, 1'b1, 1'b0, 3'b001};
      tv[3]  = '{1'b1, 1'b1, 1'b0, 3'd0,     1'b1, 1'b1, 1'b0, 3'b001};
      tv[4]  = '{1'b1, 1'b1, 1'b0, 3'd0,     1'b0, 1'b1, 1'b0, 3'b001};
      tv[5]  = '{1'b1, 1'b1, 1'b0, 3'd0,     1'b0, 1'b1, 1'b0, 3'b001};
      tv[6]  = '{1'b1, 1'b1, 1'b0, 3'd0,     1'b0, 1'b1, 1'b0, 3'b001};
      tv[7]  = '{1'b1, 1'b1, 1'b0, 3'd0,     1'b1, 1'b1, 1'b0, 3'b001};
      tv[8]  = '{1'b1, 1'b1, 1'b0, 3'd0,     1'b1, 1'b1, 1'b0, 3'b001};
      tv[9]  = '{1'b1, 1'b1, 1'b0, 3'd0,     1'b1, 1'b1, 1'b0, 3'b001};
      tv[10] = '{1'b1, 1'b1, 1'b0, 3'd0,     1'b0, 1'b1, 1'b0, 3'b001};
      tv[11] = '{1'b1, 1'b1, 1'b0, 3'd0,     1'b0, 1'b1, 1'b0, 3'b001};
      tv[12] = '{1'b1, 1'b1, 1'b0, 3'd0,     1'b0, 1'b1, 1'b0, 3'b001};
      tv[13] = '{1'b1, 1'b1, 1'b0, 3'd0,     1'b0, 1'b0, 1'b1, 3'b001};
      tv[14] = '{1'b1, 1'b1, 1'b0, 3'd0,     1'b0, 1'b0, 1'b0, 3'b001};
      tv[15] = '{1'b1, 1'b1, 1'b0, 3'd0,     1'b0, 1'b0, 1'b0, 3'b001};
      tv[16] = '{1'b1, 1'b1, 1'b0, 3'd0,     1'b0, 1'b0, 1'b0, 3'b001};
      tv[17] = '{1'b1, 1'b1, 1'b0, 3'd0,     1'b0, 1'b0, 1'b0, 3'b001};
      tv[18] = '{1'b1, 1'b1, 1'b0, 3'd0,     1'b1, 1'b1, 1'b0, 3'b001};
      for (int i = 0; i < 19; i++) begin
         reset      = tv[i].rst;
         enable     = tv[i].en;
         color_load = tv[i].load;
         color_sel  = tv[i].sel;
         step();
         chk($sformatf("row%0d led_out", i), int'(led_out), int'(tv[i].led));
         chk($sformatf("row%0d bursting", i), int'(bursting), int'(tv[i].bur));
         chk($sformatf("row%0d burst_done", i), int'(burst_done), int'(tv[i].done));
         chk($sformatf("row%0d active_color", i), int'(active_color), int'(tv[i].col));
      end
      color_load = 1'b0;

      measure(2, 3'b011, 0, len, hi, dn);
      chk("blue burst len after mid-burst load", len, 12);
      chk("blue burst high cycles", hi, 6);
      chk("blue burst_done", dn, 1);
      chk("color kept through space", int'(active_color), 1);
      wait_mark(40, n, hi);
      chk("space length before yellow", n, 5);
      chk("led low in space", hi, 0);
      chk("yellow active at entry", int'(active_color), 3);
      chk("yellow led at entry", int'(led_out), 1);
      measure(0, 3'd0, 0, len, hi, dn);
      chk("yellow burst len", len, 8);
      chk("yellow burst high cycles", hi, 4);
      chk("yellow burst_done", dn, 1);

      color_sel  = 3'b100;
      color_load = 1'b1;
      step();
      color_load = 1'b0;
      wait_mark(40, n, hi);
      chk("unknown color no burst", n, 40);
      chk("unknown color led stays low", hi, 0);
      chk("unknown color not bursting", int'(bursting), 0);

      color_sel  = 3'b010;
      color_load = 1'b1;
      step();
      color_load = 1'b0;
      chk("same-cycle load starts burst", int'(bursting), 1);
      chk("same-cycle load color", int'(active_color), 2);
      measure(0, 3'b010, 7, len, hi, dn);
      chk("green burst completes after enable drop", len, 20);
      chk("green burst high cycles", hi, 10);
      chk("green burst_done", dn, 1);
      wait_mark(20, n, hi);
      chk("disabled goes idle", n, 20);
      chk("idle led low", hi, 0);

      enable = 1'b1;
      step();
      chk("restart green bursting", int'(bursting), 1);
      step();
      chk("led high before reset", int'(led_out), 1);
      reset = 1'b0;
      step();
      chk("reset led_out", int'(led_out), 0);
      chk("reset bursting", int'(bursting), 0);
      chk("reset burst_done", int'(burst_done), 0);
      chk("reset active_color", int'(active_color), 4);
      reset = 1'b1;
      wait_mark(30, n, hi);
      chk("no burst after reset without load", n, 30);
      chk("led low after reset", hi, 0);
      color_sel  = 3'b000;
      color_load = 1'b1;
      step();
      color_load = 1'b0;
      chk("red starts after load", int'(bursting), 1);
      chk("red active_color", int'(active_color), 0);
      measure(0, 3'd0, 0, len, hi, dn);
      chk("red burst len", len, 16);
      chk("red burst high cycles", hi, 8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
